// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes, handshake FSM encodings and a sizing helper.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic W_IDLE = 1'b0;
  localparam logic W_RESP = 1'b1;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  // Keeps a one-register bank at a legal 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_regbank.sv
// Register bank: byte-enable write port, index read mux, per-register write strobe.
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IW       = idx_width(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_idx,
  input  logic [DW-1:0]          wr_data,
  input  logic [DW/8-1:0]        wr_strb,
  input  logic [IW-1:0]          rd_idx,
  output logic [DW-1:0]          rd_data,
  output logic [NUM_REGS*DW-1:0] reg_out,
  output logic [NUM_REGS-1:0]    wr_strobe
);

  logic [DW-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_strobe <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // Strobe fires on every addressed write, even with no byte lanes enabled.
        wr_strobe[i] <= wr_en && (wr_idx == IW'(i));
        if (wr_en && (wr_idx == IW'(i))) begin
          for (int b = 0; b < DW / 8; b++) begin
            if (wr_strb[b]) regs_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IW'(i)) rd_data = regs_q[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_out[g*DW +: DW] = regs_q[g];
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder over a register bank; independent write and read handshake FSMs.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS         = 16
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic [C_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  input  logic [2:0]                       S_AXI_ARPROT,
  output logic [C_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] REG_OUT,
  output logic [NUM_REGS-1:0]              WR_STROBE
);

  localparam int unsigned DW       = C_AXI_DATA_WIDTH;
  localparam int unsigned AW       = C_AXI_ADDR_WIDTH;
  localparam int unsigned IW       = idx_width(NUM_REGS);
  localparam int unsigned ADDR_LSB = $clog2(DW / 8);

  logic running_q;

  logic          w_state_q, aw_held_q, w_held_q, bvalid_q;
  logic [1:0]    bresp_q;
  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic [DW/8-1:0] wstrb_q;

  logic          r_state_q, rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;

  logic          aw_hs, w_hs, ar_hs, commit, wr_in_range, rd_in_range;
  logic [AW-1:0] cur_awaddr, wr_word, rd_word;
  logic [DW-1:0] cur_wdata, bank_rd;
  logic [DW/8-1:0] cur_wstrb;

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) running_q <= 1'b0;
    else                running_q <= 1'b1;
  end

  assign S_AXI_AWREADY = running_q && (w_state_q == W_IDLE) && !aw_held_q;
  assign S_AXI_WREADY  = running_q && (w_state_q == W_IDLE) && !w_held_q;
  assign S_AXI_ARREADY = running_q && (r_state_q == R_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Either side may complete this cycle or have been held from an earlier one.
  assign cur_awaddr = aw_hs ? S_AXI_AWADDR : awaddr_q;
  assign cur_wdata  = w_hs ? S_AXI_WDATA : wdata_q;
  assign cur_wstrb  = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign commit     = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign wr_word     = cur_awaddr >> ADDR_LSB;
  assign rd_word     = S_AXI_ARADDR >> ADDR_LSB;
  assign wr_in_range = wr_word < AW'(NUM_REGS);
  assign rd_in_range = rd_word < AW'(NUM_REGS);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs) awaddr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (w_state_q == W_IDLE) begin
        if (commit) begin
          aw_held_q <= 1'b0;
          w_held_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
          w_state_q <= W_RESP;
        end else begin
          if (aw_hs) aw_held_q <= 1'b1;
          if (w_hs)  w_held_q  <= 1'b1;
        end
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q  <= 1'b0;
        w_state_q <= W_IDLE;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else if (r_state_q == R_IDLE) begin
      if (ar_hs) begin
        // Bank updates on this same edge, so a colliding write is not yet visible.
        rdata_q   <= rd_in_range ? bank_rd : '0;
        rresp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        rvalid_q  <= 1'b1;
        r_state_q <= R_DATA;
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q  <= 1'b0;
      r_state_q <= R_IDLE;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;

  axi4_lite_regbank #(
    .DW       (DW),
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_regbank (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .wr_en     (commit && wr_in_range),
    .wr_idx    (wr_word[IW-1:0]),
    .wr_data   (cur_wdata),
    .wr_strb   (cur_wstrb),
    .rd_idx    (rd_word[IW-1:0]),
    .rd_data   (bank_rd),
    .reg_out   (REG_OUT),
    .wr_strobe (WR_STROBE)
  );

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite responder exposing a bank of NUM_REGS read/write registers to a bus master, e.g. our AXI4-Lite master block or a CPU interconnect. It accepts write address and write data in either order or together, applies WSTRB byte enables, and answers reads with registered data. Register contents drive fabric logic directly; a per-register strobe flags every bus write.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width; 32 or 64 only.
C_AXI_ADDR_WIDTH, 32, address bus width.
NUM_REGS, 16, number of registers; 1..256.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_AWPROT  in  3  ignored
S_AXI_WDATA  in  C_AXI_DATA_WIDTH  write data
S_AXI_WSTRB  in  C_AXI_DATA_WIDTH/8  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_AXI_ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_ARPROT  in  3  ignored
S_AXI_RDATA  out  C_AXI_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
REG_OUT  out  NUM_REGS*C_AXI_DATA_WIDTH  flattened register contents; register i at bits [i*DW +: DW]
WR_STROBE  out  NUM_REGS  one-cycle pulse, bit i set on the cycle register i updates

Behaviour:
- Reset, asynchronous while ARESETN=0: all registers 0; AWREADY, WREADY, ARREADY, BVALID, RVALID, WR_STROBE = 0; BRESP, RRESP, RDATA = 0; both FSMs idle; any in-flight transaction is dropped.
- A "running" flop sets on the first clock edge after reset release. All READY outputs are gated by it, so no READY is asserted in the cycle reset deasserts.
- Address decode: index = ADDR >> log2(DW/8); low address bits are ignored. index >= NUM_REGS is out of range.
- Write FSM states W_IDLE and W_RESP:
  - W_IDLE: AWREADY = running & !aw_held; WREADY = running & !w_held. Each handshake latches its payload and sets its held flag.
  - Commit happens on the edge where both sides are complete, whether held earlier or handshaking now, including simultaneous AW and W in one cycle. On that edge: in-range index updates only the bytes whose WSTRB bit is 1, and WR_STROBE[index] pulses for one cycle, even when WSTRB=0. BVALID is set with BRESP=OKAY (00), or SLVERR (10) with no update when out of range. Held flags clear and the FSM goes to W_RESP.
  - W_RESP: AWREADY = WREADY = 0. BVALID and BRESP hold until BVALID & BREADY, then the FSM returns to W_IDLE.
  - Latency: the register and BVALID are visible 1 cycle after the last handshake. Back-to-back writes take at least 2 cycles each.
- Read FSM states R_IDLE and R_DATA:
  - R_IDLE: ARREADY = running.
  - On AR handshake: RDATA is loaded with the register value (0 when out of range), RRESP = OKAY or SLVERR, RVALID = 1, and the FSM goes to R_DATA.
  - R_DATA: ARREADY = 0. RDATA, RRESP and RVALID hold until RVALID & RREADY, then the FSM returns to R_IDLE.
- Simultaneous read and write commit to the same register on one edge: the read returns the pre-write value.
- Read and write FSMs are fully independent; neither blocks the other.
- RDATA is not cleared after a handshake; it holds its last value.

Decomposition:
- Shared package axi4_lite_pkg holds the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, plus the write and read state encodings.
- One natural sub-module, axi4_lite_regbank: NUM_REGS registers with a byte-enable write port, an index read mux, and WR_STROBE generation. The top level keeps both handshake FSMs.

Test Plan:
- AW and W together, addr 0x08, data 0xDEADBEEF, WSTRB 0xF, BREADY=1 → next cycle REG_OUT[2]=0xDEADBEEF, WR_STROBE=0x0004, BVALID=1 with BRESP=00 for 1 cycle.
- AW at cycle 0, W at cycle 3, addr 0x04, data 0x12345678, WSTRB 0x5 over prior 0xFFFFFFFF → AWREADY low for cycles 1-3; REG_OUT[1]=0xFF34FF78 at cycle 4.
- W before AW, BREADY held low for 5 cycles → BVALID stays 1 with BRESP stable; AWREADY and WREADY stay 0 until the B handshake completes.
- Read addr 0x08 after the first test, RREADY low for 3 cycles → RVALID=1, RDATA=0xDEADBEEF held stable; ARREADY=0 until the R handshake.
- Write and read to 0x40 with NUM_REGS=16 → BRESP=10, RRESP=10, RDATA=0, no WR_STROBE, all registers unchanged.
- Reset pulse while BVALID=1 and RVALID=1 → both drop immediately and REG_OUT clears to 0; READYs rise only on the second edge after release.
